// File: rtl/pulse_shaper_pkg.sv
// Shared types and helpers for the pulse shaper: FSM state encoding and the
// width of the pending-trigger counter.
package pulse_shaper_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACTIVE = 2'd1,
        ST_GAP    = 2'd2
    } state_e;

    localparam int QDEPTH_DEF = 4;

    // Bits needed to count 0..qdepth inclusive.
    function automatic int pend_w(input int qdepth);
        return $clog2(qdepth + 1);
    endfunction

    localparam int PEND_W_DEF = pend_w(QDEPTH_DEF);

endpackage

// File: rtl/event_queue_cnt.sv
// Saturating up/down counter of queued triggers; a request to count past
// QDEPTH is dropped and reported as a one-cycle registered drop pulse.
module event_queue_cnt
    import pulse_shaper_pkg::*;
#(
    parameter int QDEPTH = QDEPTH_DEF,
    parameter int CW     = pend_w(QDEPTH)
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          inc_i,
    input  logic          dec_i,
    output logic [CW-1:0] count_o,
    output logic          full_o,
    output logic          empty_o,
    output logic          drop_o
);

    logic [CW-1:0] count_q, count_d;
    logic          drop_q, drop_d;

    assign full_o  = (count_q == CW'(QDEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign drop_o  = drop_q;

    always_comb begin
        count_d = count_q;
        drop_d  = 1'b0;
        if (inc_i) begin
            if (full_o) drop_d  = 1'b1;
            else        count_d = count_q + CW'(1);
        end else if (dec_i && !empty_o) begin
            count_d = count_q - CW'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            count_q <= '0;
            drop_q  <= 1'b0;
        end else begin
            count_q <= count_d;
            drop_q  <= drop_d;
        end
    end

endmodule

// File: rtl/pulse_shaper.sv
// Turns one-cycle trigger strobes into width-controlled level pulses (stretch)
// or level toggles, with a guaranteed low gap and a queue of pending triggers.
module pulse_shaper
    import pulse_shaper_pkg::*;
#(
    parameter int WIDTH_BITS = 8,
    parameter int GAP        = 2,
    parameter int QDEPTH     = QDEPTH_DEF
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic                      trig_i,
    input  logic                      mode_i,
    input  logic [WIDTH_BITS-1:0]     width_i,
    output logic                      level_out_o,
    output logic                      busy_o,
    output logic [pend_w(QDEPTH)-1:0] pending_o,
    output logic                      overflow_o
);

    localparam int GAP_W = (GAP > 1) ? $clog2(GAP) : 1;

    state_e                state_q, state_d;
    logic [WIDTH_BITS-1:0] cnt_q, cnt_d;
    logic [GAP_W-1:0]      gap_q, gap_d;
    logic                  level_q, level_d;
    logic                  mode_q, mode_d;
    logic                  busy_q;
    logic                  start;
    logic                  q_inc, q_dec, q_full, q_empty;
    logic                  unused_full;

    // Pulses only start from IDLE; a trigger arriving then is consumed
    // directly and never touches the queue.
    assign q_inc       = trig_i && !start;
    assign q_dec       = start && !trig_i;
    assign unused_full = q_full;

    event_queue_cnt #(
        .QDEPTH (QDEPTH)
    ) u_queue (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .inc_i   (q_inc),
        .dec_i   (q_dec),
        .count_o (pending_o),
        .full_o  (q_full),
        .empty_o (q_empty),
        .drop_o  (overflow_o)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        gap_d   = gap_q;
        level_d = level_q;
        mode_d  = mode_q;
        start   = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (trig_i || !q_empty) begin
                    start   = 1'b1;
                    mode_d  = mode_i;
                    cnt_d   = (width_i == '0) ? '0 : width_i - WIDTH_BITS'(1);
                    level_d = mode_i ? ~level_q : 1'b1;
                    state_d = ST_ACTIVE;
                end
            end
            ST_ACTIVE: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - WIDTH_BITS'(1);
                end else if (!mode_q) begin
                    level_d = 1'b0;
                    gap_d   = GAP_W'(GAP - 1);
                    state_d = ST_GAP;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_GAP: begin
                level_d = 1'b0;
                if (gap_q != '0) gap_d = gap_q - GAP_W'(1);
                else             state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            gap_q   <= '0;
            level_q <= 1'b0;
            mode_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            gap_q   <= gap_d;
            level_q <= level_d;
            mode_q  <= mode_d;
            // Registered view of the current cycle's activity.
            busy_q  <= (state_q != ST_IDLE) || !q_empty;
        end
    end

    assign level_out_o = level_q;
    assign busy_o      = busy_q;

endmodule

// File: tb/tb_pulse_shaper.sv
// Bench for pulse_shaper: a timeline model (pulse windows, free time, queue
// count) predicts every output cycle by cycle, plus directed edge timing checks.
module tb_pulse_shaper;
    import pulse_shaper_pkg::*;

    localparam int WB = 8;
    localparam int GP = 2;
    localparam int QD = 4;
    localparam int PW = pend_w(QD);

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          trig = 1'b0;
    logic          mode = 1'b0;
    logic [WB-1:0] width = '0;
    logic          level, busy, ovf;
    logic [PW-1:0] pend;

    always #5 clk = ~clk;

    pulse_shaper #(.WIDTH_BITS(WB), .GAP(GP), .QDEPTH(QD)) dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .trig_i      (trig),
        .mode_i      (mode),
        .width_i     (width),
        .level_out_o (level),
        .busy_o      (busy),
        .pending_o   (pend),
        .overflow_o  (ovf)
    );

    int checks = 0;
    int errors = 0;

    // Model: cyc_n is the current cycle; the unit is free from cycle free_at;
    // a stretch pulse stays high through cycle hi_end.
    int cyc_n, free_at, hi_end, m_pend;
    bit m_lvl, m_busy, m_ovf;
    logic [PW+2:0] exp_v;

    task automatic model_reset();
        cyc_n = 0; free_at = 0; hi_end = -1; m_pend = 0;
        m_lvl = 0; m_busy = 0; m_ovf = 0;
    endtask

    task automatic model_step(input bit t, input bit m, input int w);
        int wd;
        bit idle;
        wd     = (w == 0) ? 1 : w;
        idle   = (cyc_n >= free_at);
        m_busy = !idle || (m_pend > 0);
        m_ovf  = 0;
        if (idle && (t || m_pend > 0)) begin
            if (!t) m_pend--;
            if (!m) begin
                m_lvl = 1; hi_end = cyc_n + wd; free_at = cyc_n + wd + GP + 1;
            end else begin
                m_lvl = !m_lvl; hi_end = -1; free_at = cyc_n + wd + 1;
            end
        end else begin
            if (t) begin
                if (m_pend < QD) m_pend++;
                else             m_ovf = 1;
            end
            if (hi_end >= 0 && cyc_n + 1 > hi_end) begin
                m_lvl = 0; hi_end = -1;
            end
        end
        exp_v = {m_lvl, m_busy, PW'(m_pend), m_ovf};
    endtask

    task automatic drive(input bit t, input bit m, input int w);
        trig = t; mode = m; width = WB'(w);
        model_step(t, m, w);
        @(posedge clk); #1;
        trig = 0;
        cyc_n++;
    endtask

    task automatic do_reset();
        trig = 0;
        rst_n = 0;
        @(posedge clk); @(posedge clk);
        @(negedge clk) rst_n = 1;
        @(posedge clk); #1;
        model_reset();
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if ({level, busy, pend, ovf} !== '0) begin
            errors++;
            $display("FAIL reset_state got %b exp 0", {level, busy, pend, ovf});
        end
    endtask

    task automatic test_single();
        int rise = -1, hi = 0, busy_low = -1;
        do_reset();
        for (int i = 0; i < 24; i++) begin
            drive(i == 10, 0, 5);
            checks++;
            if ({level, busy, pend, ovf} !== exp_v) begin
                errors++;
                $display("FAIL single cyc %0d got %b exp %b", cyc_n, {level, busy, pend, ovf}, exp_v);
            end
            if (level && rise < 0) rise = cyc_n;
            if (level) hi++;
            if (cyc_n > 12 && !busy && busy_low < 0) busy_low = cyc_n;
        end
        checks++;
        if (rise !== 11 || hi !== 5 || busy_low !== 19) begin
            errors++;
            $display("FAIL single_timing rise %0d high %0d busy_low %0d exp 11 5 19", rise, hi, busy_low);
        end
    endtask

    task automatic test_back_to_back();
        int rises[$];
        int maxp = 0;
        bit prev = 0;
        do_reset();
        for (int i = 0; i < 30; i++) begin
            drive(i >= 10 && i <= 12, 0, 3);
            checks++;
            if ({level, busy, pend, ovf} !== exp_v) begin
                errors++;
                $display("FAIL b2b cyc %0d got %b exp %b", cyc_n, {level, busy, pend, ovf}, exp_v);
            end
            if (level && !prev) rises.push_back(cyc_n);
            prev = level;
            if (int'(pend) > maxp) maxp = int'(pend);
        end
        checks++;
        if (rises.size() != 3 || rises[0] != 11 || rises[1] != 17 || rises[2] != 23 || maxp != 2) begin
            errors++;
            $display("FAIL b2b_timing rises %p maxpend %0d exp 11 17 23 / 2", rises, maxp);
        end
    endtask

    task automatic test_overflow();
        int nrise = 0, novf = 0, ovf_cyc = -1, maxp = 0;
        bit prev = 0;
        do_reset();
        for (int i = 0; i < 85; i++) begin
            drive(i >= 10 && i <= 15, 0, 10);
            checks++;
            if ({level, busy, pend, ovf} !== exp_v) begin
                errors++;
                $display("FAIL ovf cyc %0d got %b exp %b", cyc_n, {level, busy, pend, ovf}, exp_v);
            end
            if (level && !prev) nrise++;
            prev = level;
            if (ovf) begin novf++; ovf_cyc = cyc_n; end
            if (int'(pend) > maxp) maxp = int'(pend);
        end
        checks++;
        if (nrise != 5 || novf != 1 || ovf_cyc != 16 || maxp != 4) begin
            errors++;
            $display("FAIL ovf_summary pulses %0d ovf %0d at %0d maxpend %0d exp 5 1 16 4", nrise, novf, ovf_cyc, maxp);
        end
    endtask

    task automatic test_toggle();
        int rise = -1, fall = -1;
        bit prev = 0;
        do_reset();
        for (int i = 0; i < 25; i++) begin
            drive(i == 10 || i == 11, 1, 4);
            checks++;
            if ({level, busy, pend, ovf} !== exp_v) begin
                errors++;
                $display("FAIL toggle cyc %0d got %b exp %b", cyc_n, {level, busy, pend, ovf}, exp_v);
            end
            if (level && !prev) rise = cyc_n;
            if (!level && prev) fall = cyc_n;
            prev = level;
        end
        checks++;
        if (rise != 11 || fall != 16) begin
            errors++;
            $display("FAIL toggle_timing rise %0d fall %0d exp 11 16", rise, fall);
        end
    endtask

    // width 0 behaves as 1; queued pulses repeat every 1+GAP+1 cycles.
    task automatic test_width0();
        int rises[$];
        int hi = 0;
        bit prev = 0;
        do_reset();
        for (int i = 0; i < 16; i++) begin
            drive(i == 5 || i == 6, 0, 0);
            checks++;
            if ({level, busy, pend, ovf} !== exp_v) begin
                errors++;
                $display("FAIL width0 cyc %0d got %b exp %b", cyc_n, {level, busy, pend, ovf}, exp_v);
            end
            if (level && !prev) rises.push_back(cyc_n);
            if (level) hi++;
            prev = level;
        end
        checks++;
        if (rises.size() != 2 || rises[0] != 6 || rises[1] != 10 || hi != 2) begin
            errors++;
            $display("FAIL width0_timing rises %p high %0d exp 6 10 / 2", rises, hi);
        end
    endtask

    task automatic test_wmax();
        int hi = 0;
        do_reset();
        for (int i = 0; i < 265; i++) begin
            drive(i == 2, 0, 255);
            checks++;
            if ({level, busy, pend, ovf} !== exp_v) begin
                errors++;
                $display("FAIL wmax cyc %0d got %b exp %b", cyc_n, {level, busy, pend, ovf}, exp_v);
            end
            if (level) hi++;
        end
        checks++;
        if (hi != 255) begin
            errors++;
            $display("FAIL wmax_high got %0d exp 255", hi);
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 1200; i++) begin
            drive($urandom_range(0, 99) < 35, 1'($urandom_range(0, 1)), int'($urandom_range(0, 6)));
            checks++;
            if ({level, busy, pend, ovf} !== exp_v) begin
                errors++;
                $display("FAIL random cyc %0d got %b exp %b", cyc_n, {level, busy, pend, ovf}, exp_v);
            end
        end
    endtask

    task automatic test_reset_mid();
        int hi = 0, rise = -1;
        do_reset();
        for (int i = 0; i < 3; i++) drive(1, 0, 10);
        checks++;
        if (level !== 1'b1 || int'(pend) != 2) begin
            errors++;
            $display("FAIL rst_mid_pre level %b pend %0d exp 1 2", level, pend);
        end
        #2 rst_n = 0;
        #1;
        checks++;
        if ({level, busy, pend, ovf} !== '0) begin
            errors++;
            $display("FAIL rst_mid_async got %b exp 0", {level, busy, pend, ovf});
        end
        @(negedge clk) rst_n = 1;
        @(posedge clk); #1;
        model_reset();
        for (int i = 0; i < 25; i++) begin
            drive(i == 20, 0, 3);
            checks++;
            if ({level, busy, pend, ovf} !== exp_v) begin
                errors++;
                $display("FAIL rst_mid_after cyc %0d got %b exp %b", cyc_n, {level, busy, pend, ovf}, exp_v);
            end
            if (level) hi++;
            if (level && rise < 0) rise = cyc_n;
        end
        checks++;
        if (rise != 21 || hi != 3) begin
            errors++;
            $display("FAIL rst_mid_newpulse rise %0d high %0d exp 21 3", rise, hi);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_overflow();
        test_toggle();
        test_width0();
        test_wmax();
        test_random();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pulse_shaper.md
# pulse_shaper

Event-to-waveform transmitter: converts one-cycle trigger strobes into clean, width-controlled level pulses (stretch mode) or level toggles (toggle mode). It guarantees a minimum low gap between pulses, so a downstream edge detector sampling `level_out` sees exactly one rising and one falling edge per trigger. Triggers arriving while a pulse is in progress are queued in a pending counter. Typical use: generating LED/strobe or inter-block handshake levels from internally generated one-cycle events.

## Interface
- `WIDTH_BITS`, default 8: width of the `width` input and the internal hold counter.
- `GAP`, default 2: minimum `level_out`-low cycles after a stretch pulse. Must be ≥1.
- `QDEPTH`, default 4: maximum queued triggers. Must be ≥1.
- `clk`, input, 1: sole clock; all state updates on the rising edge.
- `rst_n`, input, 1: reset, asynchronous assert and active-low; all state is cleared immediately.
- `trig`, input, 1: one-cycle event strobe. Each high cycle counts as one event.
- `mode`, input, 1: 0 = stretch, 1 = toggle. Sampled at pulse start.
- `width`, input, WIDTH_BITS: hold length in cycles, sampled at pulse start. A value of 0 is treated as 1.
- `level_out`, output, 1: registered shaped level.
- `busy`, output, 1: high whenever the FSM is not IDLE or `pending` is nonzero.
- `pending`, output, clog2(QDEPTH+1): number of queued triggers.
- `overflow`, output, 1: one-cycle pulse when a trigger is dropped.

## Operation
- FSM states: IDLE, ACTIVE, GAP.
- **IDLE**
  - A start occurs when `trig`=1 or `pending`>0. A trigger takes priority over a queued event; the queued event stays queued.
  - On start, latch `mode_r`=`mode` and `cnt`=max(`width`,1)−1.
  - Stretch mode: `level_out`←1. Toggle mode: `level_out`←~`level_out`.
  - Go to ACTIVE.
- **ACTIVE**
  - `level_out` is held.
  - If `cnt`≠0, decrement `cnt`.
  - If `cnt`=0:
    - Stretch mode: `level_out`←0, load the gap counter with GAP−1, go to GAP.
    - Toggle mode: go to IDLE, and apply IDLE start logic on the next cycle.
- **GAP**
  - `level_out`=0.
  - Count down; at 0, go to IDLE.
- **Queue**
  - A `trig` that does not cause a start in the same cycle increments `pending`.
  - Starting from the queue decrements `pending`.
  - `trig` and a queue start in the same cycle leave `pending` unchanged.
  - `trig` with `pending`=QDEPTH and no start in that cycle: the trigger is dropped, `overflow` pulses, and `pending` is unchanged.
- Mid-pulse changes to `mode` or `width` have no effect until the next start.
- Reset mid-pulse aborts the pulse and clears the queue. `level_out` drops to 0 asynchronously.

## Timing
- Reset values: `level_out`=0, `busy`=0, `pending`=0, `overflow`=0, state=IDLE, `mode_r`=0, all counters 0.
- Latency: `trig` sampled at edge k → `level_out` changes after edge k (visible in cycle k+1). Latency is 1 cycle.
- Stretch pulse: high for exactly max(`width`,1) cycles, then low for exactly GAP cycles. The next queued pulse rises 1 cycle after GAP ends (IDLE occupies one cycle).
- Stretch period, back-to-back from the queue: max(`width`,1)+GAP+1 cycles.
- Toggle mode: consecutive level changes are at least max(`width`,1)+1 cycles apart.
- `overflow` is registered and asserts the cycle after the dropped `trig`.
- `busy` and `pending` are registered.
- `width`=2^WIDTH_BITS−1 must work without counter wrap.

## Structure
- `pulse_shaper_pkg` holds:
  - localparam state encodings ST_IDLE=2'd0, ST_ACTIVE=2'd1, ST_GAP=2'd2;
  - the derived width constant for `pending`.
- One sub-module, `event_queue_cnt`: a saturating up/down counter with `inc`, `dec`, `full`, `empty` and `drop` outputs. It owns the `pending` and `overflow` logic.
- The FSM, hold counter and gap counter live in `pulse_shaper`.

## Test plan
1. Stretch, `width`=5, GAP=2, single `trig` at cycle 10 → `level_out` high in cycles 11–15, low from 16, `busy` low from cycle 19.
2. Stretch, `width`=3: three `trig` in consecutive cycles 10–12 → three pulses starting at cycles 11, 17 and 23, each 3 cycles high. `pending` peaks at 2.
3. Stretch, `width`=10: six triggers during the first pulse → `pending` saturates at 4, `overflow` pulses once on the 6th trigger, and 5 pulses in total are emitted.
4. Toggle, `width`=4: triggers at cycles 10 and 11 → `level_out` rises in cycle 11 and falls in cycle 16.
5. `width`=0, stretch mode → 1-cycle high pulse followed by GAP low cycles.
6. `rst_n` asserted in cycle 3 of a pulse with `pending`=2 → `level_out`=0 and `pending`=0 immediately. After release, no pulse is emitted until a new `trig`.
